mem_writeback_cycle: RTL and testbench

//  Memory + writeback stages of the 5-stage RV32 pipeline; the producer side of the decode-stage

---
 rtl/mem_writeback_cycle_pkg.sv | 28 ++
 rtl/mem_writeback_cycle_load_store_align.sv | 58 +++++
 rtl/mem_writeback_cycle.sv | 172 +++++++++++++++++
 tb/tb_mem_writeback_cycle.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_writeback_cycle_pkg.sv
// Shared encodings for the memory/writeback stages: register-write load codes,
// result-source and store-size selects, and the data-memory handshake FSM states.
package mem_writeback_cycle_pkg;

    localparam logic [2:0] LD_NONE   = 3'b000;
    localparam logic [2:0] LD_WORD   = 3'b001;
    localparam logic [2:0] LD_BYTE_S = 3'b010;
    localparam logic [2:0] LD_HALF_S = 3'b011;
    localparam logic [2:0] LD_BYTE_U = 3'b100;
    localparam logic [2:0] LD_HALF_U = 3'b101;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;
    localparam logic [1:0] RES_CSR  = 2'b11;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_BYTE = 2'b01;
    localparam logic [1:0] MW_HALF = 2'b10;
    localparam logic [1:0] MW_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } mem_state_e;

endpackage

// File: rtl/mem_writeback_cycle_load_store_align.sv
// Byte-lane steering for the data-memory port: store strobes/replicated data
// and load lane selection with sign or zero extension.
module load_store_align
    import mem_writeback_cycle_pkg::*;
(
    input  logic [1:0]  mem_write_i,
    input  logic [2:0]  load_code_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_word_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wstrb_o = 4'b0000;
        wdata_o = store_data_i;
        case (mem_write_i)
            MW_BYTE: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            MW_HALF: begin
                wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{store_data_i[15:0]}};
            end
            MW_WORD: wstrb_o = 4'b1111;
            default: wstrb_o = 4'b0000;
        endcase
    end

    always_comb begin
        lane_byte = load_word_i[7:0];
        case (addr_lo_i)
            2'd1:    lane_byte = load_word_i[15:8];
            2'd2:    lane_byte = load_word_i[23:16];
            2'd3:    lane_byte = load_word_i[31:24];
            default: lane_byte = load_word_i[7:0];
        endcase
        // Halfword lane ignores addr[0]; misaligned halves are not split.
        lane_half = addr_lo_i[1] ? load_word_i[31:16] : load_word_i[15:0];

        load_data_o = load_word_i;
        case (load_code_i)
            LD_BYTE_S: load_data_o = {{24{lane_byte[7]}}, lane_byte};
            LD_HALF_S: load_data_o = {{16{lane_half[15]}}, lane_half};
            LD_BYTE_U: load_data_o = {24'd0, lane_byte};
            LD_HALF_U: load_data_o = {16'd0, lane_half};
            default:   load_data_o = load_word_i;
        endcase
    end

endmodule

// File: rtl/mem_writeback_cycle.sv
// Memory and writeback stages: EX/MEM and MEM/WB registers, valid/ready data-memory
// handshake FSM with upstream stall, and the register-file write-port result mux.
module mem_writeback_cycle
    import mem_writeback_cycle_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      RegWriteE,
    input  logic [1:0]      ResultSrcE,
    input  logic [1:0]      MemWriteE,
    input  logic [XLEN-1:0] ALUResultE,
    input  logic [XLEN-1:0] WriteDataE,
    input  logic [XLEN-1:0] CSRDataE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RDE,
    output logic [XLEN-1:0] ALUResultM,
    output logic [4:0]      RDM,
    output logic [2:0]      RegWriteM,
    output logic            MemStall,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [2:0]      RegWriteW,
    output logic [4:0]      RDW,
    output logic [XLEN-1:0] ResultW
);

    logic [2:0]      reg_write_m_q;
    logic [1:0]      result_src_m_q;
    logic [1:0]      mem_write_m_q;
    logic [XLEN-1:0] alu_result_m_q;
    logic [XLEN-1:0] write_data_m_q;
    logic [XLEN-1:0] csr_data_m_q;
    logic [XLEN-1:0] pc_plus4_m_q;
    logic [4:0]      rd_m_q;

    logic [2:0]      reg_write_w_q;
    logic [1:0]      result_src_w_q;
    logic [XLEN-1:0] alu_result_w_q;
    logic [XLEN-1:0] load_data_w_q;
    logic [XLEN-1:0] csr_data_w_q;
    logic [XLEN-1:0] pc_plus4_w_q;
    logic [4:0]      rd_w_q;

    mem_state_e      state_q, state_d;
    logic            is_store, is_load, mem_op, completing, req_valid;
    logic [XLEN-1:0] load_data;

    assign is_store = (mem_write_m_q != MW_NONE);
    assign is_load  = (result_src_m_q == RES_LOAD);
    assign mem_op   = is_store | is_load;

    always_comb begin
        state_d    = state_q;
        req_valid  = 1'b0;
        completing = 1'b0;
        case (state_q)
            ST_IDLE, ST_REQ: begin
                if (mem_op) begin
                    req_valid = 1'b1;
                    if (dmem_req_ready) begin
                        completing = is_store;
                        state_d    = is_store ? ST_IDLE : ST_RESP;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_RESP: begin
                if (dmem_rvalid) begin
                    completing = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign MemStall = mem_op & ~completing;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_m_q  <= LD_NONE;
            result_src_m_q <= RES_ALU;
            mem_write_m_q  <= MW_NONE;
            alu_result_m_q <= '0;
            write_data_m_q <= '0;
            csr_data_m_q   <= '0;
            pc_plus4_m_q   <= '0;
            rd_m_q         <= '0;
        end else if (!MemStall) begin
            reg_write_m_q  <= RegWriteE;
            result_src_m_q <= ResultSrcE;
            mem_write_m_q  <= MemWriteE;
            alu_result_m_q <= ALUResultE;
            write_data_m_q <= WriteDataE;
            csr_data_m_q   <= CSRDataE;
            pc_plus4_m_q   <= PCPlus4E;
            rd_m_q         <= RDE;
        end
    end

    load_store_align u_align (
        .mem_write_i  (mem_write_m_q),
        .load_code_i  (reg_write_m_q),
        .addr_lo_i    (alu_result_m_q[1:0]),
        .store_data_i (write_data_m_q),
        .load_word_i  (dmem_rdata),
        .wstrb_o      (dmem_wstrb),
        .wdata_o      (dmem_wdata),
        .load_data_o  (load_data)
    );

    // A stalled MEM instruction must not reach WB yet, so WB takes a bubble each stall cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_w_q  <= LD_NONE;
            result_src_w_q <= RES_ALU;
            alu_result_w_q <= '0;
            load_data_w_q  <= '0;
            csr_data_w_q   <= '0;
            pc_plus4_w_q   <= '0;
            rd_w_q         <= '0;
        end else if (MemStall) begin
            reg_write_w_q <= LD_NONE;
        end else begin
            reg_write_w_q  <= reg_write_m_q;
            result_src_w_q <= result_src_m_q;
            alu_result_w_q <= alu_result_m_q;
            load_data_w_q  <= load_data;
            csr_data_w_q   <= csr_data_m_q;
            pc_plus4_w_q   <= pc_plus4_m_q;
            rd_w_q         <= rd_m_q;
        end
    end

    always_comb begin
        ResultW = alu_result_w_q;
        case (result_src_w_q)
            RES_LOAD: ResultW = load_data_w_q;
            RES_PC4:  ResultW = pc_plus4_w_q;
            RES_CSR:  ResultW = csr_data_w_q;
            default:  ResultW = alu_result_w_q;
        endcase
    end

    assign ALUResultM     = alu_result_m_q;
    assign RDM            = rd_m_q;
    assign RegWriteM      = reg_write_m_q;
    assign dmem_req_valid = req_valid;
    assign dmem_we        = is_store;
    assign dmem_addr      = {alu_result_m_q[XLEN-1:2], 2'b00};
    assign RegWriteW      = reg_write_w_q;
    assign RDW            = rd_w_q;

endmodule

// File: tb/tb_mem_writeback_cycle.sv
// Directed bench for mem_writeback_cycle: writeback results checked against a scoreboard
// queue filled as instructions are issued; handshake and alignment checked at each step.
module tb_mem_writeback_cycle;

    logic        clk, rst;
    logic [2:0]  RegWriteE;
    logic [1:0]  ResultSrcE, MemWriteE;
    logic [31:0] ALUResultE, WriteDataE, CSRDataE, PCPlus4E;
    logic [4:0]  RDE;
    logic [31:0] ALUResultM;
    logic [4:0]  RDM;
    logic [2:0]  RegWriteM;
    logic        MemStall, dmem_req_valid, dmem_req_ready, dmem_we, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic [2:0]  RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;

    mem_writeback_cycle #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .CSRDataE(CSRDataE),
        .PCPlus4E(PCPlus4E), .RDE(RDE),
        .ALUResultM(ALUResultM), .RDM(RDM), .RegWriteM(RegWriteM), .MemStall(MemStall),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  rw;
        logic [4:0]  rd;
        logic [31:0] res;
    } wb_t;

    wb_t sb_q[$];
    wb_t exp_wb;
    int  tests_run    = 0;
    int  tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] rw, input logic [1:0] rs, input logic [1:0] mw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] csr,
                         input logic [31:0] pc4, input logic [4:0] rd);
        RegWriteE  = rw;
        ResultSrcE = rs;
        MemWriteE  = mw;
        ALUResultE = alu;
        WriteDataE = wd;
        CSRDataE   = csr;
        PCPlus4E   = pc4;
        RDE        = rd;
    endtask

    task automatic nop();
        drive(3'd0, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every architectural write leaving WB must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && RegWriteW != 3'b000) begin
            if (sb_q.size() == 0) begin
                check("wb_unexpected_write", {29'd0, RegWriteW}, 32'd0);
            end else begin
                exp_wb = sb_q.pop_front();
                check("wb_regwrite", {29'd0, RegWriteW}, {29'd0, exp_wb.rw});
                check("wb_rd", {27'd0, RDW}, {27'd0, exp_wb.rd});
                check("wb_result", ResultW, exp_wb.res);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rvalid    = 1'b0;
        dmem_rdata     = 32'd0;
        nop();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ResultW", ResultW, 32'd0);
        check("rst_RegWriteW", {29'd0, RegWriteW}, 32'd0);
        check("rst_RDW", {27'd0, RDW}, 32'd0);
        check("rst_MemStall", {31'd0, MemStall}, 32'd0);
        check("rst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
        check("rst_we", {31'd0, dmem_we}, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_wstrb", {28'd0, dmem_wstrb}, 32'd0);
        check("rst_ALUResultM", ALUResultM, 32'd0);
        check("rst_RDM", {27'd0, RDM}, 32'd0);
        check("rst_RegWriteM", {29'd0, RegWriteM}, 32'd0);
        rst = 1'b1;
        step();

        // add (ALU=5) -> jal (PC+4=0x24) -> csrr, back to back
        drive(3'd1, 2'b00, 2'b00, 32'd5, 32'd0, 32'd0, 32'd0, 5'd3);
        sb_q.push_back('{rw: 3'd1, rd: 5'd3, res: 32'd5});
        step();
        drive(3'd1, 2'b10, 2'b00, 32'h99, 32'd0, 32'd0, 32'h24, 5'd1);
        sb_q.push_back('{rw: 3'd1, rd: 5'd1, res: 32'h24});
        @(negedge clk);
        check("add_ALUResultM", ALUResultM, 32'd5);
        check("add_RDM", {27'd0, RDM}, 32'd3);
        check("add_after_1_edge_RegWriteW", {29'd0, RegWriteW}, 32'd0);
        step();
        drive(3'd1, 2'b11, 2'b00, 32'h77, 32'd0, 32'h1234_5678, 32'h28, 5'd9);
        sb_q.push_back('{rw: 3'd1, rd: 5'd9, res: 32'h1234_5678});
        @(negedge clk);
        check("add_after_2_edges_ResultW", ResultW, 32'd5);
        step();
        nop();
        @(negedge clk);
        check("jal_next_cycle_ResultW", ResultW, 32'h24);
        step();

        // sb 0xAB @0x103 accepted in the first cycle
        dmem_req_ready = 1'b1;
        drive(3'd0, 2'b00, 2'b01, 32'h103, 32'h0000_00AB, 32'd0, 32'd0, 5'd0);
        step();
        nop();
        @(negedge clk);
        check("sb_req_valid", {31'd0, dmem_req_valid}, 32'd1);
        check("sb_we", {31'd0, dmem_we}, 32'd1);
        check("sb_addr", dmem_addr, 32'h100);
        check("sb_wstrb", {28'd0, dmem_wstrb}, 32'b1000);
        check("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        check("sb_MemStall", {31'd0, MemStall}, 32'd0);
        step();

        // lh signed @0x102, rvalid the cycle after acceptance
        drive(3'd3, 2'b01, 2'b00, 32'h102, 32'd0, 32'd0, 32'd0, 5'd5);
        sb_q.push_back('{rw: 3'd3, rd: 5'd5, res: 32'hFFFF_8001});
        step();
        nop();
        @(negedge clk);
        check("lh_accept_MemStall", {31'd0, MemStall}, 32'd1);
        check("lh_req_valid", {31'd0, dmem_req_valid}, 32'd1);
        check("lh_we", {31'd0, dmem_we}, 32'd0);
        check("lh_addr", dmem_addr, 32'h100);
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h8001_1234;
        @(negedge clk);
        check("lh_resp_MemStall", {31'd0, MemStall}, 32'd0);
        check("lh_resp_req_valid", {31'd0, dmem_req_valid}, 32'd0);
        step();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;

        // lbu @0x101 with the response one cycle late
        drive(3'd4, 2'b01, 2'b00, 32'h101, 32'd0, 32'd0, 32'd0, 5'd6);
        sb_q.push_back('{rw: 3'd4, rd: 5'd6, res: 32'h0000_00F0});
        step();
        nop();
        @(negedge clk);
        check("lbu_accept_MemStall", {31'd0, MemStall}, 32'd1);
        step();
        @(negedge clk);
        check("lbu_wait_MemStall", {31'd0, MemStall}, 32'd1);
        check("lbu_wait_bubble", {29'd0, RegWriteW}, 32'd0);
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h0000_F000;
        @(negedge clk);
        check("lbu_resp_MemStall", {31'd0, MemStall}, 32'd0);
        step();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;

        // sw with req_ready low for 3 cycles; an add waits frozen in EX meanwhile
        dmem_req_ready = 1'b0;
        drive(3'd0, 2'b00, 2'b11, 32'h200, 32'hDEAD_BEEF, 32'd0, 32'd0, 5'd0);
        step();
        drive(3'd1, 2'b00, 2'b00, 32'h77, 32'd0, 32'd0, 32'd0, 5'd10);
        sb_q.push_back('{rw: 3'd1, rd: 5'd10, res: 32'h77});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sw_wait_MemStall", {31'd0, MemStall}, 32'd1);
            check("sw_wait_req_valid", {31'd0, dmem_req_valid}, 32'd1);
            check("sw_wait_addr", dmem_addr, 32'h200);
            check("sw_wait_wdata", dmem_wdata, 32'hDEAD_BEEF);
            check("sw_wait_wstrb", {28'd0, dmem_wstrb}, 32'b1111);
            check("sw_wait_bubble", {29'd0, RegWriteW}, 32'd0);
            step();
        end
        dmem_req_ready = 1'b1;
        @(negedge clk);
        check("sw_accept_MemStall", {31'd0, MemStall}, 32'd0);
        check("sw_accept_req_valid", {31'd0, dmem_req_valid}, 32'd1);
        step();

        // sh 0x1234ABCD @0x102 -> upper half lanes
        drive(3'd0, 2'b00, 2'b10, 32'h102, 32'h1234_ABCD, 32'd0, 32'd0, 5'd0);
        step();
        nop();
        @(negedge clk);
        check("sh_wstrb", {28'd0, dmem_wstrb}, 32'b1100);
        check("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        check("sh_MemStall", {31'd0, MemStall}, 32'd0);
        step();

        // lw abandoned by reset while waiting in RESP
        drive(3'd1, 2'b01, 2'b00, 32'h300, 32'd0, 32'd0, 32'd0, 5'd7);
        step();
        nop();
        @(negedge clk);
        check("lw_accept_MemStall", {31'd0, MemStall}, 32'd1);
        step();
        @(negedge clk);
        check("lw_resp_MemStall", {31'd0, MemStall}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_MemStall", {31'd0, MemStall}, 32'd0);
        check("midrst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
        check("midrst_RegWriteM", {29'd0, RegWriteM}, 32'd0);
        check("midrst_RDM", {27'd0, RDM}, 32'd0);
        check("midrst_ALUResultM", ALUResultM, 32'd0);
        check("midrst_addr", dmem_addr, 32'd0);
        check("midrst_wstrb", {28'd0, dmem_wstrb}, 32'd0);
        check("midrst_RegWriteW", {29'd0, RegWriteW}, 32'd0);
        check("midrst_ResultW", ResultW, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        check("late_rvalid_MemStall", {31'd0, MemStall}, 32'd0);
        check("late_rvalid_req_valid", {31'd0, dmem_req_valid}, 32'd0);
        step();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;

        // a fresh lw is requested immediately, showing the FSM is back in IDLE
        drive(3'd1, 2'b01, 2'b00, 32'h40, 32'd0, 32'd0, 32'd0, 5'd8);
        sb_q.push_back('{rw: 3'd1, rd: 5'd8, res: 32'h1122_3344});
        step();
        nop();
        @(negedge clk);
        check("post_rst_lw_req_valid", {31'd0, dmem_req_valid}, 32'd1);
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1122_3344;
        step();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;

        repeat (3) step();
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
